// File: rtl/swc_seq_if.sv
// swc_seq_if: client request/grant/done handshake plus the Swc inst/ready port.
// With SWC_SEQ_ABORT_EN defined, the interface also carries abort[1:0] and aborted.
interface swc_seq_if;
   logic [1:0]  req;
   logic [47:0] delay;
   logic [1:0]  grant;
   logic [1:0]  done;
   logic        busy;
   logic [11:0] swc_inst;
   logic        swc_inst_en;
   logic        swc_ready;
`ifdef SWC_SEQ_ABORT_EN
   logic [1:0]  abort;
   logic        aborted;
   modport master (output req, delay, swc_ready, abort,
                   input grant, done, busy, swc_inst, swc_inst_en, aborted);
   modport slave (input req, delay, swc_ready, abort,
                  output grant, done, busy, swc_inst, swc_inst_en, aborted);
`else
   modport master (output req, delay, swc_ready,
                   input grant, done, busy, swc_inst, swc_inst_en);
   modport slave (input req, delay, swc_ready,
                  output grant, done, busy, swc_inst, swc_inst_en);
`endif
endinterface

// File: rtl/swc_seq.sv
// swc_seq: two-channel delay sequencer driving one Swc counter (LD0/LD1/LD2/CCD, wait ready).
// SWC_SEQ_ABORT_EN defined adds abort handling (CCS plus counter clear) and the aborted flag.
module swc_seq #(
   parameter bit PRIO_FIXED = 1'b0
) (
   input logic      clock,
   input logic      reset,
   swc_seq_if.slave bus
);
   typedef enum logic [3:0] {IDLE, LD0, LD1, LD2, CCD, WAIT, DONE, ABRT, CLR0, CLR1, CLR2} state_t;
   state_t state, nxt;
   logic [23:0] d, nd, dsel;
   logic w, nw, win, last, kill;
   logic [11:0] ninst;
   // last holds the channel granted most recently; the other one wins a tie
   assign win = &bus.req ? (PRIO_FIXED ? 1'b0 : ~last) : bus.req[1];
   assign dsel = win ? bus.delay[47:24] : bus.delay[23:0];
`ifdef SWC_SEQ_ABORT_EN
   logic ab;
   assign kill = bus.abort[w] && state inside {LD0, LD1, LD2, CCD, WAIT};
   always_ff @(posedge clock) begin
      if (reset) begin
         ab <= 1'b0;
         bus.aborted <= 1'b0;
      end else begin
         ab <= kill ? 1'b1 : state == IDLE ? 1'b0 : ab;
         bus.aborted <= state == DONE && ab;
      end
   end
`else
   assign kill = 1'b0;
`endif
   always_comb begin
      nxt = state;
      nd = d;
      nw = w;
      case (state)
         IDLE: if (|bus.req) begin
            nw = win;
            nd = dsel;
            nxt = dsel == '0 ? DONE : LD0;
         end
         LD0: nxt = LD1;
         LD1: nxt = LD2;
         LD2: nxt = CCD;
         CCD: nxt = WAIT;
         WAIT: nxt = bus.swc_ready ? DONE : WAIT;
         ABRT: nxt = CLR0;
         CLR0: nxt = CLR1;
         CLR1: nxt = CLR2;
         CLR2: nxt = DONE;
         default: nxt = IDLE;
      endcase
      if (kill) nxt = ABRT;
      ninst = nxt == LD0  ? {4'h1, nd[7:0]}   :
              nxt == LD1  ? {4'h2, nd[15:8]}  :
              nxt == LD2  ? {4'h3, nd[23:16]} :
              nxt == CCD  ? 12'h700 :
              nxt == ABRT ? 12'h800 :
              nxt == CLR0 ? 12'h100 :
              nxt == CLR1 ? 12'h200 :
              nxt == CLR2 ? 12'h300 : 12'h000;
   end
   // grant and done are decoded from the current state, so done lands the cycle after DONE
   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
         d <= '0;
         w <= 1'b0;
         last <= 1'b1;
         bus.grant <= 2'b00;
         bus.done <= 2'b00;
         bus.busy <= 1'b0;
         bus.swc_inst <= 12'h000;
         bus.swc_inst_en <= 1'b0;
      end else begin
         state <= nxt;
         d <= nd;
         w <= nw;
         if (state == DONE) last <= w;
         bus.grant <= state == IDLE && nxt != IDLE ? 2'b01 << nw : 2'b00;
         bus.done <= state == DONE ? 2'b01 << w : 2'b00;
         bus.busy <= nxt != IDLE;
         bus.swc_inst <= ninst;
         bus.swc_inst_en <= |ninst;
      end
   end
endmodule

// File: tb/tb_swc_seq.sv
// tb_swc_seq: table vectors, hand sequences and a randomized timing model for swc_seq,
// with a behavioural Swc counter answering swc_ready.
module tb_swc_seq;
   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;
   swc_seq_if bus0 ();
   swc_seq_if bus1 ();
   swc_seq #(.PRIO_FIXED(1'b0)) dut0 (.clock(clock), .reset(reset), .bus(bus0));
   swc_seq #(.PRIO_FIXED(1'b1)) dut1 (.clock(clock), .reset(reset), .bus(bus1));
   logic [24:0] swc0, swc1;
   int pass_n = 0, total_n = 0;
   function automatic logic [24:0] swc_step(input logic [24:0] s, input logic en, input logic [11:0] i);
      logic run;
      logic [23:0] c;
      {run, c} = s;
      if (en) begin
         case (i[11:8])
            4'h1: c[7:0] = i[7:0];
            4'h2: c[15:8] = i[7:0];
            4'h3: c[23:16] = i[7:0];
            4'h7: begin run = 1'b1; c = c == 0 ? c : c - 24'd1; end
            4'h8: run = 1'b0;
            default: ;
         endcase
      end else if (run && c != 0) c = c - 24'd1;
      return {run, c};
   endfunction
   always @(posedge clock) begin
      swc0 <= reset ? 25'd0 : swc_step(swc0, bus0.swc_inst_en, bus0.swc_inst);
      swc1 <= reset ? 25'd0 : swc_step(swc1, bus1.swc_inst_en, bus1.swc_inst);
   end
   assign bus0.swc_ready = swc0[23:0] == 0;
   assign bus1.swc_ready = swc1[23:0] == 0;
   typedef struct {
      logic [1:0]  req;
      logic [47:0] delay;
      logic [1:0]  g;
      logic [47:0] insts;
      int          ens;
      int          lat;
   } vec_t;
   vec_t vecs[6];
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total_n++;
      if (act === exp) pass_n++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask
   task automatic tick;
      @(posedge clock);
      #1;
   endtask
   task automatic run_vec(input string name, input vec_t v);
      int gcyc, dcyc, ens, bsy;
      logic [1:0] gval, dval;
      logic [47:0] obs;
      gcyc = -1; dcyc = -1; ens = 0; bsy = 0; gval = 0; dval = 0; obs = 0;
      bus0.req = v.req;
      bus0.delay = v.delay;
      for (int k = 1; k <= v.lat + 4 && dcyc < 0; k++) begin
         tick;
         bus0.req = 2'b00;
         if (k <= 4) obs = {obs[35:0], bus0.swc_inst};
         ens += int'(bus0.swc_inst_en);
         bsy += int'(bus0.busy);
         if (bus0.grant != 0 && gcyc < 0) begin gcyc = k; gval = bus0.grant; end
         if (bus0.done != 0) begin dcyc = k; dval = bus0.done; end
      end
      if (dcyc > 0 && dcyc < 4) obs = obs << (12 * (4 - dcyc));
      check({name, "_grant_cyc"}, 64'(gcyc), 64'd1);
      check({name, "_grant"}, 64'(gval), 64'(v.g));
      check({name, "_done_cyc"}, 64'(dcyc), 64'(v.lat));
      check({name, "_done"}, 64'(dval), 64'(v.g));
      check({name, "_insts"}, 64'(obs), 64'(v.insts));
      check({name, "_en_cycles"}, 64'(ens), 64'(v.ens));
      check({name, "_busy_cycles"}, 64'(bsy), 64'(v.lat - 1));
      repeat (2) tick;
   endtask
   function automatic logic [17:0] outs0();
      return {bus0.grant, bus0.done, bus0.busy, bus0.swc_inst_en, bus0.swc_inst};
   endfunction
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      logic [1:0] g0[$], g1[$];
      logic [47:0] obs;
      int bsy, dn, k;
      bit m_act;
      int t_acc, t_done;
      logic [23:0] md, d0, d1;
      logic mw, mlast;
      logic [1:0] r, eg, ed;
      logic eb;
      logic [11:0] ei;
      vecs[0] = '{2'b01, {24'h0, 24'h000003}, 2'b01, {12'h103, 12'h200, 12'h300, 12'h700}, 4, 9};
      vecs[1] = '{2'b10, {24'h000005, 24'h0}, 2'b10, {12'h105, 12'h200, 12'h300, 12'h700}, 4, 11};
      vecs[2] = '{2'b01, {24'h0, 24'h0}, 2'b01, 48'h0, 0, 2};
      vecs[3] = '{2'b10, {24'h000102, 24'h0}, 2'b10, {12'h102, 12'h201, 12'h300, 12'h700}, 4, 264};
      vecs[4] = '{2'b11, {24'h000007, 24'h000001}, 2'b01, {12'h101, 12'h200, 12'h300, 12'h700}, 4, 7};
      vecs[5] = '{2'b11, {24'h0, 24'h000005}, 2'b10, 48'h0, 0, 2};
      bus0.req = 0; bus0.delay = 0; bus1.req = 0; bus1.delay = 0;
`ifdef SWC_SEQ_ABORT_EN
      bus0.abort = 0; bus1.abort = 0;
`endif
      repeat (2) tick;
      check("reset_outs0", 64'(outs0()), 64'd0);
      check("reset_outs1", 64'({bus1.grant, bus1.done, bus1.busy, bus1.swc_inst_en, bus1.swc_inst}), 64'd0);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) run_vec($sformatf("vec%0d", i), vecs[i]);
      // held tie on both instances: round-robin alternates, fixed priority keeps ch0
      bus0.req = 2'b11; bus0.delay = {24'd2, 24'd2};
      bus1.req = 2'b11; bus1.delay = {24'd2, 24'd2};
      k = 0;
      while ((g0.size() < 4 || g1.size() < 3) && k < 80) begin
         tick;
         k++;
         if (bus0.grant != 0 && g0.size() < 4) g0.push_back(bus0.grant);
         if (bus1.grant != 0 && g1.size() < 3) g1.push_back(bus1.grant);
      end
      bus0.req = 0; bus1.req = 0;
      check("rr_grants", 64'({g0[0], g0[1], g0[2], g0[3]}), 64'({2'b01, 2'b10, 2'b01, 2'b10}));
      check("fixed_grants", 64'({g1[0], g1[1], g1[2]}), 64'({2'b01, 2'b01, 2'b01}));
      repeat (12) tick;
      // long delay on ch1, interrupted by reset in WAIT
      bus0.req = 2'b10; bus0.delay = {24'hABCDEF, 24'h0};
      obs = 0; bsy = 0; dn = 0;
      for (int c = 1; c <= 20; c++) begin
         tick;
         bus0.req = 0;
         if (c <= 4) obs = {obs[35:0], bus0.swc_inst};
         bsy += int'(bus0.busy);
         dn += int'(bus0.done != 0);
      end
      check("long_insts", 64'(obs), 64'({12'h1EF, 12'h2CD, 12'h3AB, 12'h700}));
      check("long_busy", 64'(bsy), 64'd20);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("midreset_outs", 64'(outs0()), 64'd0);
      for (int c = 0; c < 12; c++) begin
         tick;
         dn += int'(bus0.done != 0) + int'(bus0.busy);
      end
      check("midreset_no_done", 64'(dn), 64'd0);
      run_vec("after_reset", '{2'b01, {24'h0, 24'h000002}, 2'b01, {12'h102, 12'h200, 12'h300, 12'h700}, 4, 8});
      // randomized traffic against a timing model built from the accept/grant/done rules
      reset = 1'b1;
      repeat (2) tick;
      reset = 1'b0;
      m_act = 0; mlast = 1; mw = 0; md = 0; t_acc = 0; t_done = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         k = cyc - t_acc;
         eg = m_act && k == 1 ? 2'b01 << mw : 2'b00;
         ed = m_act && cyc == t_done ? 2'b01 << mw : 2'b00;
         eb = m_act && k >= 1 && cyc < t_done;
         ei = !(m_act && md != 0) ? 12'h000 : k == 1 ? {4'h1, md[7:0]} : k == 2 ? {4'h2, md[15:8]} :
              k == 3 ? {4'h3, md[23:16]} : k == 4 ? 12'h700 : 12'h000;
         check($sformatf("rand_c%0d", cyc), 64'(outs0()), 64'({eg, ed, eb, ei != 0, ei}));
         if (m_act && cyc >= t_done) begin
            mlast = mw;
            m_act = 0;
         end
         r = 2'($urandom_range(0, 3));
         d0 = 24'($urandom_range(0, 6));
         d1 = 24'($urandom_range(0, 6));
         bus0.req = r;
         bus0.delay = {d1, d0};
         if (!m_act && r != 0) begin
            mw = r == 2'b11 ? ~mlast : r[1];
            md = mw ? d1 : d0;
            t_acc = cyc;
            t_done = md == 0 ? cyc + 2 : cyc + int'(md) + 6;
            m_act = 1;
         end
         tick;
      end
      bus0.req = 0;
      repeat (20) tick;
`ifdef SWC_SEQ_ABORT_EN
      bus0.req = 2'b01; bus0.delay = {24'h0, 24'h000100};
      for (int c = 1; c <= 8; c++) begin
         tick;
         bus0.req = 0;
      end
      bus0.abort = 2'b01;
      obs = 0;
      for (int c = 9; c <= 14; c++) begin
         tick;
         bus0.abort = 0;
         if (c <= 12) obs = {obs[35:0], bus0.swc_inst};
      end
      check("abort_insts", 64'(obs), 64'({12'h800, 12'h100, 12'h200, 12'h300}));
      check("abort_done", 64'({bus0.done, bus0.aborted}), 64'({2'b01, 1'b1}));
      check("abort_ready", 64'(bus0.swc_ready), 64'd1);
      repeat (2) tick;
`endif
      $display("%0d/%0d checks passed", pass_n, total_n);
      $finish;
   end
endmodule
